// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: PC width, PC type, fetch FSM states.
// Optional return-stack occupancy guard enabled by RAS_OVF_GUARD_EN.
package fetch_pkg;

  localparam int FETCH_PC_W = 14;
  localparam int FETCH_RESET_PC = 0;

  typedef logic [FETCH_PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ras_occ_cnt.sv
// Saturating up/down occupancy counter tracking return-stack depth.
// Saturates at 2^W on push; never underflows on pop.
module ras_occ_cnt #(
  parameter int W = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic empty
);

  localparam logic [W:0] FULL = (W+1)'(1) << W;

  logic [W:0] occ_q;
  logic [W:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    if (inc && occ_q != FULL) begin
      occ_d = occ_q + 1'b1;
    end else if (dec && occ_q != '0) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign empty = (occ_q == '0);

endmodule

// File: rtl/ras_fetch_ctrl.sv
// Next-PC generation and fetch control feeding the return-address stack.
// Define RAS_OVF_GUARD_EN to suppress pops from an empty stack.
module ras_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W           = FETCH_PC_W,
  parameter int RESET_PC       = FETCH_RESET_PC,
  parameter int RAS_DEPTH_LOG2 = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pd_call,
  input  logic            pd_ret,
  input  logic            pd_jump,
  input  logic [PC_W-1:0] pd_target,
  input  logic [PC_W-1:0] ras_ra,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            d_ready,
  output logic [PC_W-1:0] f_pc,
  output logic            f_valid,
  output logic            ras_push,
  output logic            ras_pop,
  output logic [PC_W-1:0] ras_pc
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] f_pc_q, f_pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            fire;
  logic            ret_ok;

`ifdef RAS_OVF_GUARD_EN
  logic occ_empty;

  ras_occ_cnt #(
    .W(RAS_DEPTH_LOG2)
  ) u_occ (
    .clk  (clk),
    .rst  (rst),
    .inc  (ras_push),
    .dec  (ras_pop),
    .empty(occ_empty)
  );

  assign ret_ok = ~occ_empty;
`else
  logic unused_cfg;
  assign unused_cfg = (RAS_DEPTH_LOG2 != 0);
  assign ret_ok     = 1'b1;
`endif

  assign pc_inc = f_pc_q + 1'b1;
  assign fire   = (state_q == RUN) & d_ready & ~redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      f_pc_q  <= PC_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      f_pc_q  <= f_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  // An empty-stack return falls through to the next bundle.
  always_comb begin
    f_pc_d = f_pc_q;
    if (redirect) begin
      f_pc_d = redirect_pc;
    end else if (fire && pd_call) begin
      f_pc_d = pd_target;
    end else if (fire && pd_ret) begin
      f_pc_d = ret_ok ? ras_ra : pc_inc;
    end else if (fire && pd_jump) begin
      f_pc_d = pd_target;
    end else if (fire) begin
      f_pc_d = pc_inc;
    end
  end

  always_comb begin
    f_pc     = f_pc_q;
    f_valid  = (state_q == RUN);
    ras_push = fire & pd_call;
    ras_pop  = fire & pd_ret & ~pd_call & ret_ok;
    ras_pc   = pc_inc;
  end

endmodule

// File: tb/tb_ras_fetch_ctrl.sv
// Directed bench for ras_fetch_ctrl: reset, sequencing, calls, redirects,
// wrap-around and empty-stack returns.
module tb_ras_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        pd_call, pd_ret, pd_jump;
  logic [13:0] pd_target, ras_ra, redirect_pc;
  logic        redirect, d_ready;
  logic [13:0] f_pc, ras_pc;
  logic        f_valid, ras_push, ras_pop;

  int checks = 0;
  int errors = 0;

  ras_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pd_call    (pd_call),
    .pd_ret     (pd_ret),
    .pd_jump    (pd_jump),
    .pd_target  (pd_target),
    .ras_ra     (ras_ra),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .d_ready    (d_ready),
    .f_pc       (f_pc),
    .f_valid    (f_valid),
    .ras_push   (ras_push),
    .ras_pop    (ras_pop),
    .ras_pc     (ras_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_flags();
    pd_call  = 1'b0;
    pd_ret   = 1'b0;
    pd_jump  = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic go_to(input logic [13:0] pc);
    clr_flags();
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect = 1'b0;
    step();
  endtask

  task automatic test_reset();
    go_to(14'h123);
    d_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (f_pc !== 14'h000 || f_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async pc=%h v=%b exp pc=000 v=0", f_pc, f_valid);
    end
    step();
    rst = 1'b1;
    d_ready = 1'b1;
    pd_call = 1'b1;
    pd_target = 14'h0AA;
    #1;
    checks++;
    if (f_valid !== 1'b0 || ras_push !== 1'b0 || f_pc !== 14'h000) begin
      errors++;
      $display("FAIL boot v=%b push=%b pc=%h exp 0 0 000",
               f_valid, ras_push, f_pc);
    end
    step();
    pd_call = 1'b0;
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 14'h000) begin
      errors++;
      $display("FAIL run_after_boot v=%b pc=%h exp 1 000", f_valid, f_pc);
    end
  endtask

  task automatic test_seq_stall();
    logic [13:0] exp_pc;
    go_to(14'h010);
    d_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_pc = 14'h010 + 14'(i);
      checks++;
      if (f_pc !== exp_pc) begin
        errors++;
        $display("FAIL seq_%0d pc=%h exp %h", i, f_pc, exp_pc);
      end
    end
    d_ready = 1'b0;
    pd_call = 1'b1;
    pd_ret  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ras_push !== 1'b0 || ras_pop !== 1'b0) begin
        errors++;
        $display("FAIL stall_strobe push=%b pop=%b exp 0 0", ras_push, ras_pop);
      end
      step();
      checks++;
      if (f_pc !== 14'h013 || f_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold pc=%h v=%b exp 013 1", f_pc, f_valid);
      end
    end
    clr_flags();
    d_ready = 1'b1;
  endtask

  task automatic test_call_ret();
    go_to(14'h020);
    pd_call   = 1'b1;
    pd_target = 14'h100;
    #1;
    checks++;
    if (ras_push !== 1'b1 || ras_pop !== 1'b0 || ras_pc !== 14'h021) begin
      errors++;
      $display("FAIL call_strobe push=%b pop=%b ra=%h exp 1 0 021",
               ras_push, ras_pop, ras_pc);
    end
    step();
    pd_call = 1'b0;
    checks++;
    if (f_pc !== 14'h100) begin
      errors++;
      $display("FAIL call_target pc=%h exp 100", f_pc);
    end
    go_to(14'h105);
    pd_ret = 1'b1;
    ras_ra = 14'h021;
    #1;
    checks++;
    if (ras_pop !== 1'b1 || ras_push !== 1'b0) begin
      errors++;
      $display("FAIL ret_strobe pop=%b push=%b exp 1 0", ras_pop, ras_push);
    end
    step();
    pd_ret = 1'b0;
    checks++;
    if (f_pc !== 14'h021) begin
      errors++;
      $display("FAIL ret_target pc=%h exp 021", f_pc);
    end
    pd_jump   = 1'b1;
    pd_target = 14'h050;
    step();
    pd_jump = 1'b0;
    checks++;
    if (f_pc !== 14'h050) begin
      errors++;
      $display("FAIL jump_target pc=%h exp 050", f_pc);
    end
  endtask

  task automatic test_redirect();
    go_to(14'h030);
    pd_call     = 1'b1;
    pd_target   = 14'h100;
    redirect    = 1'b1;
    redirect_pc = 14'h2AA;
    #1;
    checks++;
    if (ras_push !== 1'b0) begin
      errors++;
      $display("FAIL redir_push push=%b exp 0", ras_push);
    end
    step();
    redirect = 1'b0;
    checks++;
    if (f_pc !== 14'h2AA || f_valid !== 1'b0 || ras_push !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush pc=%h v=%b push=%b exp 2aa 0 0",
               f_pc, f_valid, ras_push);
    end
    redirect    = 1'b1;
    redirect_pc = 14'h2BB;
    step();
    redirect = 1'b0;
    checks++;
    if (f_pc !== 14'h2BB || f_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_in_flush pc=%h v=%b exp 2bb 0", f_pc, f_valid);
    end
    pd_call = 1'b0;
    step();
    checks++;
    if (f_pc !== 14'h2BB || f_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_resume pc=%h v=%b exp 2bb 1", f_pc, f_valid);
    end
  endtask

  task automatic test_wrap_conflict();
    go_to(14'h3FFF);
    #1;
    checks++;
    if (ras_pc !== 14'h0000) begin
      errors++;
      $display("FAIL wrap_raspc ra=%h exp 0000", ras_pc);
    end
    step();
    checks++;
    if (f_pc !== 14'h0000) begin
      errors++;
      $display("FAIL wrap_seq pc=%h exp 0000", f_pc);
    end
    go_to(14'h3FFF);
    pd_call   = 1'b1;
    pd_target = 14'h200;
    #1;
    checks++;
    if (ras_push !== 1'b1 || ras_pc !== 14'h0000) begin
      errors++;
      $display("FAIL wrap_call push=%b ra=%h exp 1 0000", ras_push, ras_pc);
    end
    step();
    pd_call   = 1'b1;
    pd_ret    = 1'b1;
    pd_target = 14'h300;
    ras_ra    = 14'h111;
    #1;
    checks++;
    if (ras_push !== 1'b1 || ras_pop !== 1'b0) begin
      errors++;
      $display("FAIL callret_strobe push=%b pop=%b exp 1 0", ras_push, ras_pop);
    end
    step();
    clr_flags();
    checks++;
    if (f_pc !== 14'h300) begin
      errors++;
      $display("FAIL callret_target pc=%h exp 300", f_pc);
    end
  endtask

  task automatic test_guard();
    logic        exp_pop;
    logic [13:0] exp_pc;
`ifdef RAS_OVF_GUARD_EN
    exp_pop = 1'b0;
    exp_pc  = 14'h041;
`else
    exp_pop = 1'b1;
    exp_pc  = 14'h077;
`endif
    clr_flags();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    go_to(14'h040);
    pd_ret = 1'b1;
    ras_ra = 14'h077;
    #1;
    checks++;
    if (ras_pop !== exp_pop) begin
      errors++;
      $display("FAIL guard_pop pop=%b exp %b", ras_pop, exp_pop);
    end
    step();
    pd_ret = 1'b0;
    checks++;
    if (f_pc !== exp_pc) begin
      errors++;
      $display("FAIL guard_pc pc=%h exp %h", f_pc, exp_pc);
    end
  endtask

  initial begin
    rst         = 1'b0;
    clr_flags();
    pd_target   = '0;
    ras_ra      = '0;
    redirect_pc = '0;
    d_ready     = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    test_reset();
    test_seq_stall();
    test_call_ret();
    test_redirect();
    test_wrap_conflict();
    test_guard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_fetch_ctrl.md
Name: ras_fetch_ctrl

Overview:
Next-PC generator and fetch-control stage that sits directly upstream of the return-address stack (rastack).
- Holds the fetch bundle PC and presents fetched bundles to decode with a valid/ready handshake.
- Uses predecoded call/return/jump flags to pick the next PC.
- Drives the RAS push/pop strobes and the return address, and consumes the stack's top-of-stack `ra` for return prediction.
- Execute-stage redirects override the prediction and flush one cycle.

Parameters:
- PC_W, 14, bundle-address width (matches RAS entry width).
- RESET_PC, 0, PC loaded on reset.
- RAS_DEPTH_LOG2, 9, log2 of RAS depth; used only by the optional guard.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pd_call  input  1  predecoded: bundle at f_pc contains a call.
- pd_ret  input  1  predecoded: bundle at f_pc contains a return.
- pd_jump  input  1  predecoded: bundle at f_pc contains an unconditional direct jump.
- pd_target  input  PC_W  direct target for call/jump.
- ras_ra  input  PC_W  top-of-stack return address from rastack.
- redirect  input  1  execute-stage misprediction/exception redirect.
- redirect_pc  input  PC_W  corrected PC.
- d_ready  input  1  decode can accept a bundle.
- f_pc  output  PC_W  current fetch PC (also the instruction-memory address).
- f_valid  output  1  bundle at f_pc is valid for decode.
- ras_push  output  1  push strobe to rastack.
- ras_pop  output  1  pop strobe to rastack.
- ras_pc  output  PC_W  return address to push (f_pc+1).

Behaviour:
- Reset (rst=0, asynchronous): takes effect immediately, including mid-operation, and discards any pending redirect.
  - State=BOOT, f_pc=RESET_PC, f_valid=0, ras_push=0, ras_pop=0.
- States:
  - BOOT: one cycle, f_valid=0; then RUN.
  - RUN: f_valid=1.
  - FLUSH: one bubble, f_valid=0; then RUN.
- Fire condition: fire = (state==RUN) & d_ready & ~redirect.
- Next-PC priority, evaluated every cycle:
  1. redirect=1 (any state): f_pc<=redirect_pc, state<=FLUSH, no push/pop this cycle.
  2. fire & pd_call: f_pc<=pd_target.
  3. fire & pd_ret: f_pc<=ras_ra.
  4. fire & pd_jump: f_pc<=pd_target.
  5. fire: f_pc<=f_pc+1.
  6. otherwise: f_pc held (stall).
- RAS strobes are combinational, same cycle as fire:
  - ras_push = fire & pd_call.
  - ras_pop = fire & pd_ret & ~pd_call.
  - ras_pc = f_pc+1.
  - Push and pop are never asserted together.
- pd_call and pd_ret both set: treated as a call (push only, target path).
- Arithmetic: f_pc+1 and ras_pc wrap modulo 2^PC_W (max PC → 0, no flag).
- Flags are ignored whenever f_valid=0; no strobes in BOOT or FLUSH.
- Redirect in FLUSH restarts FLUSH with the new redirect_pc.
- While d_ready=0 in RUN: f_pc, f_valid and the predecode inputs are held stable; strobes stay 0.

Optional Feature:
RAS_OVF_GUARD_EN
- With the macro: an occupancy counter (0..2^RAS_DEPTH_LOG2), reset to 0.
  - Increments on ras_push and saturates at full; the push is still issued.
  - Decrements on ras_pop.
  - Return with occupancy 0: ras_pop suppressed and next PC = f_pc+1 (fall-through prediction).
  - Redirect does not change the counter.
- Without the macro: no counter; returns always pop and use ras_ra regardless of occupancy.

Decomposition:
- Shared package fetch_pkg holds:
  - PC width constant and the pc_t typedef.
  - fetch state enum (BOOT/RUN/FLUSH).
  - RESET_PC default.
- One natural sub-module: ras_occ_cnt (saturating up/down occupancy counter), instantiated only under RAS_OVF_GUARD_EN.

Test Plan:
- Reset: rst low mid-run with f_pc=0x123 → f_pc=0, f_valid=0 immediately; after release, one BOOT cycle, then f_valid=1 at PC 0.
- Sequential/stall: no flags, d_ready=1 for 3 cycles from 0x010 → f_pc 0x011, 0x012, 0x013. Then d_ready=0 for 2 cycles → f_pc held at 0x013, no strobes.
- Call/return: call at 0x020, pd_target=0x100 → ras_push=1, ras_pc=0x021, next f_pc=0x100. Later ret at 0x105 with ras_ra=0x021 → ras_pop=1, next f_pc=0x021.
- Redirect priority: same cycle as a call fire, redirect=1, redirect_pc=0x2AA → no push, f_pc=0x2AA, f_valid=0 for one cycle, then 1.
- Wrap and conflicts:
  - Sequential fire at 0x3FFF → f_pc=0x0000.
  - Call at 0x3FFF → ras_pc=0x0000.
  - pd_call=pd_ret=1 → push only.
- Guard (RAS_OVF_GUARD_EN): ret after reset at 0x040 → ras_pop=0, next f_pc=0x041. Without the macro, same stimulus → ras_pop=1, f_pc=ras_ra.
